// File: rtl/trap_ctrl.sv
// Trap controller for the M-mode core.
// Arbitrates synchronous exceptions, mret and machine interrupts, drains the
// pipeline before an asynchronous trap, and hands the CSR file a single
// one-cycle trap/return strobe with its cause and pc.
module trap_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            sync_exc_valid,
    input  logic [4:0]      sync_exc_code,
    input  logic [XLEN-1:0] sync_exc_pc,
    input  logic [XLEN-1:0] resume_pc,
    input  logic            mret_valid,
    input  logic            stall,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            m_eie,
    input  logic            m_tie,
    output logic            exception_pending,
    output logic            m_ret,
    output logic            asy_int,
    output logic [XLEN-1:0] m_cause,
    output logic [XLEN-1:0] pc_exc,
    output logic            flush,
    output logic            m_interrupt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_TRAP,
        S_RET,
        S_GUARD
    } state_t;

    localparam logic [4:0] CODE_EXT   = 5'd11;
    localparam logic [4:0] CODE_TIMER = 5'd7;
    localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES);

    state_t            r_state;
    logic   [3:0]      r_cnt;
    logic              r_sync1;
    logic              r_m_interrupt;
    logic              r_exception_pending;
    logic              r_m_ret;
    logic              r_asy_int;
    logic              r_flush;
    logic   [XLEN-1:0] r_m_cause;
    logic   [XLEN-1:0] r_pc_exc;

    state_t            w_next_state;
    logic   [3:0]      w_cnt_next;
    logic              w_irq_req;
    logic   [4:0]      w_irq_code;
    logic              w_latch_sync;
    logic              w_latch_irq;
    logic              w_latch_resume;
    logic              w_async;

    // External takes priority over timer when both are pending and enabled.
    assign w_irq_req  = (r_m_interrupt && m_eie) || (timer_irq && m_tie);
    assign w_irq_code = (r_m_interrupt && m_eie) ? CODE_EXT : CODE_TIMER;

    // Two-flop synchroniser for the asynchronous external interrupt line.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1       <= 1'b0;
            r_m_interrupt <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values, giving the two-stage delay; blocking would collapse it.
            r_sync1       <= ext_irq;
            r_m_interrupt <= r_sync1;
        end
    end

    // Next-state, drain counter and latch-enable decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a variable unassigned (no latches).
        w_next_state   = r_state;
        w_cnt_next     = r_cnt;
        w_latch_sync   = 1'b0;
        w_latch_irq    = 1'b0;
        w_latch_resume = 1'b0;
        w_async        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!stall && sync_exc_valid) begin
                    w_next_state = S_TRAP;
                    w_latch_sync = 1'b1;
                end else if (!stall && mret_valid) begin
                    w_next_state = S_RET;
                end else if (w_irq_req) begin
                    w_next_state = S_DRAIN;
                    w_latch_irq  = 1'b1;
                    w_cnt_next   = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                // The interrupt is committed once latched; only an older
                // faulting instruction can displace it.
                if (!stall) begin
                    if (sync_exc_valid) begin
                        w_next_state = S_TRAP;
                        w_latch_sync = 1'b1;
                        w_cnt_next   = 4'd0;
                    end else if (r_cnt <= 4'd1) begin
                        w_next_state   = S_TRAP;
                        w_latch_resume = 1'b1;
                        w_async        = 1'b1;
                        w_cnt_next     = 4'd0;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
            end
            S_TRAP:  w_next_state = S_GUARD;
            S_RET:   w_next_state = S_GUARD;
            // Gives the CSR file a cycle to update mie before re-arbitration.
            S_GUARD: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, counter and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state             <= S_IDLE;
            r_cnt               <= 4'd0;
            r_exception_pending <= 1'b0;
            r_m_ret             <= 1'b0;
            r_asy_int           <= 1'b0;
            r_flush             <= 1'b0;
            r_m_cause           <= '0;
            r_pc_exc            <= '0;
        end else begin
            r_state             <= w_next_state;
            r_cnt               <= w_cnt_next;
            r_exception_pending <= (w_next_state == S_TRAP) || (w_next_state == S_RET);
            r_m_ret             <= (w_next_state == S_RET);
            r_asy_int           <= w_async;
            r_flush             <= (w_next_state == S_TRAP) || (w_next_state == S_DRAIN);
            if (w_latch_sync) begin
                r_m_cause <= {{(XLEN-5){1'b0}}, sync_exc_code};
                r_pc_exc  <= sync_exc_pc;
            end else if (w_latch_irq) begin
                r_m_cause <= {1'b1, {(XLEN-6){1'b0}}, w_irq_code};
            end else if (w_latch_resume) begin
                r_pc_exc  <= resume_pc;
            end
        end
    end

    assign exception_pending = r_exception_pending;
    assign m_ret             = r_m_ret;
    assign asy_int           = r_asy_int;
    assign m_cause           = r_m_cause;
    assign pc_exc            = r_pc_exc;
    assign flush             = r_flush;
    assign m_interrupt       = r_m_interrupt;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: sync exception, timer and external interrupt
// traps, sync override of a drain, stalled mret, stalled drain and reset abort.
module tb_trap_ctrl;

    localparam int XLEN = 32;

    logic            clk;
    logic            nrst;
    logic            sync_exc_valid;
    logic [4:0]      sync_exc_code;
    logic [XLEN-1:0] sync_exc_pc;
    logic [XLEN-1:0] resume_pc;
    logic            mret_valid;
    logic            stall;
    logic            ext_irq;
    logic            timer_irq;
    logic            m_eie;
    logic            m_tie;
    logic            exception_pending;
    logic            m_ret;
    logic            asy_int;
    logic [XLEN-1:0] m_cause;
    logic [XLEN-1:0] pc_exc;
    logic            flush;
    logic            m_interrupt;

    int n_checks = 0;
    int n_fail   = 0;

    trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(3)) dut (
        .clk               (clk),
        .nrst              (nrst),
        .sync_exc_valid    (sync_exc_valid),
        .sync_exc_code     (sync_exc_code),
        .sync_exc_pc       (sync_exc_pc),
        .resume_pc         (resume_pc),
        .mret_valid        (mret_valid),
        .stall             (stall),
        .ext_irq           (ext_irq),
        .timer_irq         (timer_irq),
        .m_eie             (m_eie),
        .m_tie             (m_tie),
        .exception_pending (exception_pending),
        .m_ret             (m_ret),
        .asy_int           (asy_int),
        .m_cause           (m_cause),
        .pc_exc            (pc_exc),
        .flush             (flush),
        .m_interrupt       (m_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_strobes(input string tag, input logic ep, input logic mr,
                                 input logic ai, input logic fl);
        check({tag, ".exception_pending"}, 32'(exception_pending), 32'(ep));
        check({tag, ".m_ret"},             32'(m_ret),             32'(mr));
        check({tag, ".asy_int"},           32'(asy_int),           32'(ai));
        check({tag, ".flush"},             32'(flush),             32'(fl));
    endtask

    initial begin
        nrst = 1'b0; sync_exc_valid = 1'b0; sync_exc_code = 5'd0; sync_exc_pc = '0;
        resume_pc = '0; mret_valid = 1'b0; stall = 1'b0; ext_irq = 1'b0;
        timer_irq = 1'b0; m_eie = 1'b0; m_tie = 1'b0;

        // Reset state
        tick(); tick();
        check_strobes("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.m_cause", m_cause, 32'h0);
        check("reset.pc_exc", pc_exc, 32'h0);
        check("reset.m_interrupt", 32'(m_interrupt), 32'h0);
        nrst = 1'b1;
        tick();
        check_strobes("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Synchronous exception from IDLE
        sync_exc_valid = 1'b1; sync_exc_code = 5'd2; sync_exc_pc = 32'h100;
        tick();
        check_strobes("sync.trap", 1'b1, 1'b0, 1'b0, 1'b1);
        check("sync.m_cause", m_cause, 32'h0000_0002);
        check("sync.pc_exc", pc_exc, 32'h100);
        sync_exc_valid = 1'b0;
        tick();
        check_strobes("sync.guard", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Timer interrupt: three drain cycles, then an asynchronous trap
        m_tie = 1'b1; timer_irq = 1'b1; resume_pc = 32'h208;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_strobes("timer.drain", 1'b0, 1'b0, 1'b0, 1'b1);
        end
        tick();
        check_strobes("timer.trap", 1'b1, 1'b0, 1'b1, 1'b1);
        check("timer.m_cause", m_cause, 32'h8000_0007);
        check("timer.pc_exc", pc_exc, 32'h208);
        tick();
        check_strobes("timer.guard", 1'b0, 1'b0, 1'b0, 1'b0);
        m_tie = 1'b0; timer_irq = 1'b0;
        tick();
        check_strobes("timer.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // External vs timer priority and synchroniser latency
        ext_irq = 1'b1; timer_irq = 1'b1; m_eie = 1'b1; resume_pc = 32'h40C;
        tick();
        check("prio.sync1", 32'(m_interrupt), 32'h0);
        tick();
        check("prio.sync2", 32'(m_interrupt), 32'h1);
        m_tie = 1'b1;
        tick();
        check_strobes("prio.drain", 1'b0, 1'b0, 1'b0, 1'b1);
        check("prio.cause_latched", m_cause, 32'h8000_000B);
        tick(); tick(); tick();
        check_strobes("prio.trap", 1'b1, 1'b0, 1'b1, 1'b1);
        check("prio.m_cause", m_cause, 32'h8000_000B);
        check("prio.pc_exc", pc_exc, 32'h40C);
        ext_irq = 1'b0; timer_irq = 1'b0; m_eie = 1'b0; m_tie = 1'b0;
        tick(); tick();
        check_strobes("prio.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Sync exception overrides an interrupt drain
        timer_irq = 1'b1; m_tie = 1'b1;
        tick();
        check("ovr.drain_cause", m_cause, 32'h8000_0007);
        sync_exc_valid = 1'b1; sync_exc_code = 5'd5; sync_exc_pc = 32'h300;
        timer_irq = 1'b0; m_tie = 1'b0;
        tick();
        check_strobes("ovr.trap", 1'b1, 1'b0, 1'b0, 1'b1);
        check("ovr.m_cause", m_cause, 32'h0000_0005);
        check("ovr.pc_exc", pc_exc, 32'h300);
        sync_exc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_strobes("ovr.after", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // mret held off by stall
        mret_valid = 1'b1; stall = 1'b1;
        tick();
        check_strobes("mret.stall1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_strobes("mret.stall2", 1'b0, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        tick();
        check_strobes("mret.ret", 1'b1, 1'b1, 1'b0, 1'b0);
        check("mret.m_cause_hold", m_cause, 32'h0000_0005);
        check("mret.pc_exc_hold", pc_exc, 32'h300);
        mret_valid = 1'b0;
        tick();
        check_strobes("mret.guard", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Stall freezes the drain counter; dropping the request does not cancel
        timer_irq = 1'b1; m_tie = 1'b1; resume_pc = 32'h500;
        tick();
        stall = 1'b1; timer_irq = 1'b0; m_tie = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_strobes("sdrain.frozen", 1'b0, 1'b0, 1'b0, 1'b1);
        end
        stall = 1'b0;
        tick();
        check_strobes("sdrain.cnt2", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_strobes("sdrain.cnt1", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_strobes("sdrain.trap", 1'b1, 1'b0, 1'b1, 1'b1);
        check("sdrain.m_cause", m_cause, 32'h8000_0007);
        check("sdrain.pc_exc", pc_exc, 32'h500);
        tick(); tick();

        // Reset in the middle of a drain aborts it
        timer_irq = 1'b1; m_tie = 1'b1;
        tick();
        check_strobes("rst.drain", 1'b0, 1'b0, 1'b0, 1'b1);
        timer_irq = 1'b0; m_tie = 1'b0;
        nrst = 1'b0;
        #1;
        check_strobes("rst.async", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst.m_cause", m_cause, 32'h0);
        check("rst.pc_exc", pc_exc, 32'h0);
        tick();
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_strobes("rst.quiet", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
